// File: rtl/cam_pkg.sv
// Shared camera-port definitions: FSM states, RGB565->RGB444 field positions
// and default frame geometry (also used by wb_camera).
package cam_pkg;

   localparam int unsigned CAM_H_PIXELS = 160;
   localparam int unsigned CAM_V_LINES  = 120;
   localparam int unsigned CAM_ADDR_W   = 15;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT_VS = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } cam_state_e;

   // Field positions inside the RGB565 byte pair (byte0 first on the wire)
   localparam int unsigned R_MSB0 = 7;
   localparam int unsigned R_LSB0 = 4;
   localparam int unsigned G_MSB0 = 2;
   localparam int unsigned G_LSB0 = 0;
   localparam int unsigned G_BIT1 = 7;
   localparam int unsigned B_MSB1 = 4;
   localparam int unsigned B_LSB1 = 1;

   function automatic logic [11:0] rgb565_to_444(input logic [7:0] b0, input logic [7:0] b1);
      return {b0[R_MSB0:R_LSB0], b0[G_MSB0:G_LSB0], b1[G_BIT1], b1[B_MSB1:B_LSB1]};
   endfunction

endpackage

// File: rtl/cam_capture_if.sv
// Frame-buffer write port driven by cam_capture; no backpressure.
interface cam_capture_if
   import cam_pkg::*;
#(
   parameter int unsigned ADDR_W = CAM_ADDR_W
);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [11:0]       wr_data;

   modport master (output wr_en, wr_addr, wr_data);
   modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/cam_sync_edge.sv
// Generic N-bit 2-flop synchronizer with registered rise/fall detection on the
// low EDGE_W bits.
module cam_sync_edge #(
   parameter int unsigned W      = 11,
   parameter int unsigned EDGE_W = 3
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [W-1:0]      din,
   output logic [W-1:0]      dout,
   output logic [EDGE_W-1:0] rise,
   output logic [EDGE_W-1:0] fall
);
   logic [W-1:0] s1, s2, s3;

   // The third stage covers every bit so levels stay aligned with the edge flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1   <= '0;
         s2   <= '0;
         s3   <= '0;
         rise <= '0;
         fall <= '0;
      end else begin
         s1   <= din;
         s2   <= s1;
         s3   <= s2;
         rise <= s2[EDGE_W-1:0] & ~s3[EDGE_W-1:0];
         fall <= ~s2[EDGE_W-1:0] & s3[EDGE_W-1:0];
      end
   end

   assign dout = s3;
endmodule

// File: rtl/cam_capture.sv
// OV7670 pixel-capture front end: oversampled camera pins -> RGB444 frame buffer.
// Optional 2x decimation (QVGA sensor into QQVGA buffer) under CAM_CAPTURE_DECIM_EN.
module cam_capture
   import cam_pkg::*;
#(
   parameter int unsigned H_PIXELS = CAM_H_PIXELS,
   parameter int unsigned V_LINES  = CAM_V_LINES,
   parameter int unsigned ADDR_W   = CAM_ADDR_W
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          cam_Vsync,
   input  logic          cam_Href,
   input  logic          cam_Pclk,
   input  logic [7:0]    cam_data,
   input  logic          capture_req,
   output logic          busy,
   output logic          done,
   output logic          overrun,
   cam_capture_if.master fb
);
   localparam int unsigned COL_W = $clog2(H_PIXELS + 1);
   localparam int unsigned ROW_W = $clog2(V_LINES + 1);
   localparam logic [COL_W-1:0]  COL_LIM   = COL_W'(H_PIXELS);
   localparam logic [ROW_W-1:0]  ROW_LIM   = ROW_W'(V_LINES);
   localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_PIXELS);

   logic [10:0] lvl;
   logic [2:0]  rise, fall;

   cam_sync_edge #(.W(11), .EDGE_W(3)) u_sync (
      .clk   (clk),
      .rst_n (rst),
      .din   ({cam_data, cam_Vsync, cam_Href, cam_Pclk}),
      .dout  (lvl),
      .rise  (rise),
      .fall  (fall)
   );

   logic       pclk_rise, href_fall, vs_rise, vs_fall, href_lvl, byte_ok;
   logic [7:0] data;
   logic       unused_sync;

   assign pclk_rise   = rise[0];
   assign href_fall   = fall[1];
   assign vs_rise     = rise[2];
   assign vs_fall     = fall[2];
   assign href_lvl    = lvl[1];
   assign data        = lvl[10:3];
   assign byte_ok     = pclk_rise & href_lvl;
   assign unused_sync = ^{lvl[2], lvl[0], rise[1], fall[0]};

   cam_state_e        state;
   logic              phase, line_taken;
   logic [7:0]        byte0;
   logic [COL_W-1:0]  col;
   logic [ROW_W-1:0]  row;
   logic [ADDR_W-1:0] base;
   logic              keep_px, line_keep;

`ifdef CAM_CAPTURE_DECIM_EN
   logic px_odd, ln_odd;

   // Source pixel/line parity; only even/even survives into the buffer
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         px_odd <= 1'b0;
         ln_odd <= 1'b0;
      end else if (state == ST_WAIT_VS) begin
         px_odd <= 1'b0;
         ln_odd <= 1'b0;
      end else if (state == ST_CAPTURE) begin
         if (href_fall) begin
            px_odd <= 1'b0;
            ln_odd <= ~ln_odd;
         end else if (byte_ok && phase) begin
            px_odd <= ~px_odd;
         end
      end
   end

   assign keep_px   = ~px_odd & ~ln_odd;
   assign line_keep = ~ln_odd;
`else
   assign keep_px   = 1'b1;
   assign line_keep = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= ST_IDLE;
         busy       <= 1'b0;
         done       <= 1'b0;
         overrun    <= 1'b0;
         fb.wr_en   <= 1'b0;
         fb.wr_addr <= '0;
         fb.wr_data <= '0;
         phase      <= 1'b0;
         line_taken <= 1'b0;
         byte0      <= '0;
         col        <= '0;
         row        <= '0;
         base       <= '0;
      end else begin
         done     <= 1'b0;
         fb.wr_en <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (capture_req) begin
                  state   <= ST_WAIT_VS;
                  busy    <= 1'b1;
                  overrun <= 1'b0;
               end
            end
            ST_WAIT_VS: begin
               if (vs_fall) begin
                  state      <= ST_CAPTURE;
                  row        <= '0;
                  col        <= '0;
                  base       <= '0;
                  phase      <= 1'b0;
                  line_taken <= 1'b0;
               end
            end
            ST_CAPTURE: begin
               // col/row saturate at their limits so long lines or frames cannot wrap
               if (href_fall) begin
                  phase      <= 1'b0;
                  col        <= '0;
                  line_taken <= 1'b0;
                  if (line_keep && row != ROW_LIM) row <= row + ROW_W'(1);
                  if (line_taken && row < ROW_LIM) base <= base + LINE_STEP;
               end else if (byte_ok) begin
                  phase <= ~phase;
                  if (!phase) begin
                     byte0 <= data;
                  end else if (keep_px) begin
                     line_taken <= 1'b1;
                     if (col < COL_LIM && row < ROW_LIM) begin
                        fb.wr_en   <= 1'b1;
                        fb.wr_addr <= base + ADDR_W'(col);
                        fb.wr_data <= rgb565_to_444(byte0, data);
                     end else begin
                        overrun <= 1'b1;
                     end
                     if (col != COL_LIM) col <= col + COL_W'(1);
                  end
               end
               if (vs_rise) begin
                  state <= ST_DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end
            end
            ST_DONE: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end
endmodule
